// File: rtl/systolic_skew_feeder.sv
// ----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Purpose:
//   Accepts one k-step beat per cycle (N A-lanes and N B-lanes). It emits those
//   beats into the west (A) and north (B) edges of an NxN systolic array with
//   the diagonal skew the array needs. Lane i of each edge is a register chain
//   of depth i+1. A value accepted on edge E therefore appears on lane i at
//   edge E+i. Every cycle without an accepted beat pushes a zero into all
//   chains. Zeros add nothing to any PE sum, so the chains never stall.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   begin a job (sampled only in IDLE)
//   k_len     in   [7:0] inner dimension K, latched on accepted start
//   in_valid  in   a_vec/b_vec carry one beat
//   in_ready  out  feeder accepts a beat this cycle (high only in FEED)
//   a_vec     in   [N*W-1:0] A[i][k], lane i = bits [W*i +: W]
//   b_vec     in   [N*W-1:0] B[k][j], lane j = bits [W*j +: W]
//   a_edge    out  [N*W-1:0] lane i -> a_in of PE(i,0), registered
//   b_edge    out  [N*W-1:0] lane j -> b_in of PE(0,j), registered
//   busy      out  job in progress (FEED, FLUSH, DONE)
//   done      out  one-cycle pulse once the job is fully skewed out
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
//   in_ready depends only on the FSM state, never on in_valid. Data offered
//   while in_ready is low is ignored and zeros enter the chains instead.
//
// The FSM state is held in state_q for hierarchical observation by checkers.
// ----------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [7:0]     k_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a_vec,
  input  logic [N*W-1:0] b_vec,
  output logic [N*W-1:0] a_edge,
  output logic [N*W-1:0] b_edge,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // FLUSH lasts N-1 cycles so the last beat reaches lane N-1 before DONE.
  localparam int FW = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((N > 1) ? (N - 2) : 0);

  state_t        state_q, state_d;
  logic [7:0]    k_q, k_d;
  logic [7:0]    beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          accept;

  assign in_ready = (state_q == S_FEED);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len != 8'd0) begin
            state_d = S_FEED;
            k_d     = k_len;
            beat_d  = '0;
          end else begin
            // An empty job skips straight to the completion pulse.
            state_d = S_DONE;
          end
        end
      end
      S_FEED: begin
        if (accept) begin
          if (beat_q == k_q - 8'd1) begin
            flush_d = '0;
            state_d = (N > 1) ? S_FLUSH : S_DONE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          state_d = S_DONE;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Skew chains: lane i has depth i+1. Stage 0 takes the accepted beat or a
  // zero bubble, and the last stage drives the edge output directly.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] a_pipe_q [0:i];
    logic [W-1:0] b_pipe_q [0:i];
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;

    assign a_in = accept ? a_vec[W*i +: W] : '0;
    assign b_in = accept ? b_vec[W*i +: W] : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int d = 0; d <= i; d++) begin
          a_pipe_q[d] <= '0;
          b_pipe_q[d] <= '0;
        end
      end else begin
        a_pipe_q[0] <= a_in;
        b_pipe_q[0] <= b_in;
        for (int d = 1; d <= i; d++) begin
          a_pipe_q[d] <= a_pipe_q[d-1];
          b_pipe_q[d] <= b_pipe_q[d-1];
        end
      end
    end

    assign a_edge[W*i +: W] = a_pipe_q[i];
    assign b_edge[W*i +: W] = b_pipe_q[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// ----------------------------------------------------------------------------
// tb_systolic_skew_feeder
//
// Directed bench for systolic_skew_feeder with N=4, W=16. Inputs change on the
// falling edge and outputs are sampled on the falling edge, after the rising
// edge that produced them. "Step s" means the falling edge that follows edge
// E+s, where E is the edge that accepts the first beat of a job.
// ----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

  localparam int N = 4;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic           clk;
  logic           rst;
  logic           start;
  logic [7:0]     k_len;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] a_vec;
  logic [N*W-1:0] b_vec;
  logic [N*W-1:0] a_edge;
  logic [N*W-1:0] b_edge;
  logic           busy;
  logic           done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  systolic_skew_feeder #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .a_edge   (a_edge),
    .b_edge   (b_edge),
    .busy     (busy),
    .done     (done)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Job description used by the expected-value functions.
  int cur_k;
  int cur_tag;
  int off [8];   // edge offset (relative to E) at which beat j is accepted

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] l0, input logic [15:0] l1,
                                     input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Beat j, lane i payloads. B is the bitwise complement of A so that B lanes
  // carry negative two's-complement values, which must pass bit-exact.
  function automatic logic [15:0] av(input int j, input int i);
    return 16'(cur_tag * 256 + j * 16 + i + 1);
  endfunction

  function automatic logic [15:0] bv(input int j, input int i);
    return ~av(j, i);
  endfunction

  // Lane i at step s shows the beat accepted at offset s-i, otherwise zero.
  function automatic logic [63:0] exp_a(input int s);
    logic [63:0] r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < cur_k; j++)
        if (off[j] + i == s) r[16*i +: 16] = av(j, i);
    return r;
  endfunction

  function automatic logic [63:0] exp_b(input int s);
    logic [63:0] r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < cur_k; j++)
        if (off[j] + i == s) r[16*i +: 16] = bv(j, i);
    return r;
  endfunction

  // Present whatever the job wants accepted on edge E+e. With no beat due,
  // in_valid drops and junk data is held on the bus.
  task automatic drive_edge(input int e);
    in_valid = 1'b0;
    a_vec    = {4{16'hDEAD}};
    b_vec    = {4{16'hBEEF}};
    for (int j = 0; j < cur_k; j++) begin
      if (off[j] == e) begin
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
          a_vec[16*i +: 16] = av(j, i);
          b_vec[16*i +: 16] = bv(j, i);
        end
      end
    end
  endtask

  // Run a job of k beats. Beat 0 is accepted at E. Beat 1 comes after `gap`
  // idle cycles, and later beats follow back to back. With noise set, start
  // is pulsed once in FEED and once in FLUSH. k_len is also changed after the
  // job starts.
  task automatic run_job(input int k, input int gap, input bit noise, input int tag);
    int last;
    int done_s;
    cur_k   = k;
    cur_tag = tag;
    for (int j = 0; j < k; j++) off[j] = (j == 0) ? 0 : j + gap;
    last   = off[k-1];
    done_s = last + N - 1;

    start = 1'b1;
    k_len = 8'(k);
    step();
    chk($sformatf("t%0d_feed_ready", tag), {63'd0, in_ready}, 64'd1);
    chk($sformatf("t%0d_feed_busy", tag), {63'd0, busy}, 64'd1);
    start = 1'b0;
    k_len = 8'd9;
    drive_edge(0);

    for (int s = 0; s <= done_s + 1; s++) begin
      step();
      chk($sformatf("t%0d_s%0d_a_edge", tag, s), a_edge, exp_a(s));
      chk($sformatf("t%0d_s%0d_b_edge", tag, s), b_edge, exp_b(s));
      chk($sformatf("t%0d_s%0d_done", tag, s), {63'd0, done}, {63'd0, (s == done_s)});
      chk($sformatf("t%0d_s%0d_busy", tag, s), {63'd0, busy}, {63'd0, (s <= done_s)});
      chk($sformatf("t%0d_s%0d_ready", tag, s), {63'd0, in_ready}, {63'd0, (s < last)});
      drive_edge(s + 1);
      start = noise && (s == 1 || s == last + 1);
      k_len = noise ? 8'd7 : 8'd9;
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [63:0] t1_a [5];
  logic [63:0] t1_b [5];

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    k_len    = 8'd0;
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    cur_k    = 0;
    cur_tag  = 0;
    for (int j = 0; j < 8; j++) off[j] = 0;

    // Reset state
    step();
    step();
    chk("rst_a_edge", a_edge, 64'd0);
    chk("rst_b_edge", b_edge, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Single beat, A lanes {1,2,3,4}, B lanes {5,6,7,8}
    t1_a[0] = pk(16'd1, 16'd0, 16'd0, 16'd0);
    t1_a[1] = pk(16'd0, 16'd2, 16'd0, 16'd0);
    t1_a[2] = pk(16'd0, 16'd0, 16'd3, 16'd0);
    t1_a[3] = pk(16'd0, 16'd0, 16'd0, 16'd4);
    t1_a[4] = 64'd0;
    t1_b[0] = pk(16'd5, 16'd0, 16'd0, 16'd0);
    t1_b[1] = pk(16'd0, 16'd6, 16'd0, 16'd0);
    t1_b[2] = pk(16'd0, 16'd0, 16'd7, 16'd0);
    t1_b[3] = pk(16'd0, 16'd0, 16'd0, 16'd8);
    t1_b[4] = 64'd0;
    start = 1'b1;
    k_len = 8'd1;
    step();
    chk("t1_feed_ready", {63'd0, in_ready}, 64'd1);
    start    = 1'b0;
    in_valid = 1'b1;
    a_vec    = pk(16'd1, 16'd2, 16'd3, 16'd4);
    b_vec    = pk(16'd5, 16'd6, 16'd7, 16'd8);
    for (int s = 0; s < 5; s++) begin
      step();
      in_valid = 1'b0;
      a_vec    = '0;
      b_vec    = '0;
      chk($sformatf("t1_s%0d_a_edge", s), a_edge, t1_a[s]);
      chk($sformatf("t1_s%0d_b_edge", s), b_edge, t1_b[s]);
      chk($sformatf("t1_s%0d_done", s), {63'd0, done}, {63'd0, (s == 3)});
      chk($sformatf("t1_s%0d_busy", s), {63'd0, busy}, {63'd0, (s < 4)});
      chk($sformatf("t1_s%0d_ready", s), {63'd0, in_ready}, 64'd0);
    end

    // Three beats, two-cycle bubble after beat 0, start noise in FEED and FLUSH
    run_job(3, 2, 1'b1, 2);

    // Empty job: k_len=0 with in_valid held high and junk on the bus
    start    = 1'b1;
    k_len    = 8'd0;
    in_valid = 1'b1;
    a_vec    = {4{16'h1234}};
    b_vec    = {4{16'h5678}};
    step();
    start = 1'b0;
    chk("k0_done", {63'd0, done}, 64'd1);
    chk("k0_busy", {63'd0, busy}, 64'd1);
    chk("k0_ready", {63'd0, in_ready}, 64'd0);
    chk("k0_a_edge", a_edge, 64'd0);
    chk("k0_b_edge", b_edge, 64'd0);
    step();
    chk("k0_done_clr", {63'd0, done}, 64'd0);
    chk("k0_idle_busy", {63'd0, busy}, 64'd0);
    chk("k0_idle_a_edge", a_edge, 64'd0);
    in_valid = 1'b0;

    // Reset asserted in FEED after 2 of 4 beats
    cur_k   = 4;
    cur_tag = 3;
    for (int j = 0; j < 4; j++) off[j] = j;
    start = 1'b1;
    k_len = 8'd4;
    step();
    start = 1'b0;
    drive_edge(0);
    step();
    drive_edge(1);
    step();
    in_valid = 1'b0;
    chk("abort_pre_a_edge", a_edge, pk(av(1, 0), av(0, 1), 16'd0, 16'd0));
    chk("abort_pre_b_edge", b_edge, pk(bv(1, 0), bv(0, 1), 16'd0, 16'd0));
    rst = 1'b1;
    #1;
    chk("abort_async_a_edge", a_edge, 64'd0);
    chk("abort_async_b_edge", b_edge, 64'd0);
    chk("abort_async_busy", {63'd0, busy}, 64'd0);
    chk("abort_async_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("abort_no_done", {63'd0, done}, 64'd0);
    chk("abort_held_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    step();
    chk("abort_after_done", {63'd0, done}, 64'd0);

    // Fresh job after the abort, two back-to-back beats
    run_job(2, 0, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter N, default 4: array dimension; number of A lanes and B lanes.
REQ-002 Parameter W, default 16: lane width in bits, signed two's complement; matches PE operand width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a job; sampled only in IDLE.
REQ-006 k_len  input  8  inner dimension K of the job; latched on accepted start.
REQ-007 in_valid  input  1  a_vec/b_vec hold one k-step beat.
REQ-008 in_ready  output  1  feeder accepts a beat this cycle.
REQ-009 a_vec  input  N*W  A[i][k] for i=0..N-1; lane i = bits [W*i+W-1 : W*i].
REQ-010 b_vec  input  N*W  B[k][j] for j=0..N-1; same lane packing.
REQ-011 a_edge  output  N*W  lane i drives a_in of PE(i,0).
REQ-012 b_edge  output  N*W  lane j drives b_in of PE(0,j).
REQ-013 busy  output  1  job in progress.
REQ-014 done  output  1  one-cycle pulse: job fully skewed out.

Function
REQ-015 FSM states IDLE, FEED, FLUSH, DONE; encoding free.
REQ-016 IDLE: in_ready=0, busy=0; start=1 with k_len!=0 -> FEED, latch k_len, beat counter <= 0.
REQ-017 IDLE: start=1 with k_len==0 -> DONE directly; no beats accepted.
REQ-018 FEED: in_ready=1, busy=1; beat accepted on edge where in_valid&in_ready=1; counter increments per accepted beat.
REQ-019 FEED -> FLUSH on the edge accepting beat number k_len (counter == k_len-1).
REQ-020 FLUSH: in_ready=0, busy=1; lasts exactly N-1 cycles (flush counter), then -> DONE; for N=1, FLUSH is skipped (FEED -> DONE).
REQ-021 DONE: done=1, busy=1, in_ready=0 for exactly one cycle, then -> IDLE.
REQ-022 start asserted outside IDLE is ignored; k_len changes outside IDLE are ignored.
REQ-023 Skew: lane i (A and B alike) is a register chain of depth i+1; lane 0 output updates on the accepting edge E, lane i value appears on the output at edge E+i.
REQ-024 Every cycle without an accepted beat (in_valid=0 in FEED, or any non-FEED state) shifts zero into all lane chain inputs; chains never stall.
REQ-025 Zero bubbles preserve the PE alignment A[i][k]xB[k][j] at PE(i,j) and add 0 to every sum; no other compensation required.
REQ-026 Last beat accepted at edge E_last: lane N-1 shows it through E_last+N-1; done is high in the cycle after edge E_last+N-1... i.e. DONE entered at edge E_last+N-1; all a_edge/b_edge lanes are zero from edge E_last+N.
REQ-027 Data is passed bit-exact; no arithmetic, no sign extension, no saturation.
REQ-028 a_edge and b_edge are driven directly from registers (no combinational path from inputs).

Reset
REQ-029 While rst=1: state=IDLE, all chain registers, counters and latched k_len = 0; a_edge=0, b_edge=0, in_ready=0, busy=0, done=0.
REQ-030 rst asserted mid-job (FEED/FLUSH/DONE) aborts the job immediately with no done pulse; after release the block is in IDLE and accepts a new start.

Verification
REQ-031 N=4, start k_len=1, one beat a_vec lanes {1,2,3,4}, b_vec {5,6,7,8} accepted at E -> a_edge lane0=1 at E, lane1=2 at E+1, lane2=3 at E+2, lane3=4 at E+3, each for one cycle, others 0; b_edge likewise 5..8; done high in cycle after E+3; all lanes 0 from E+4.
REQ-032 N=4, k_len=3 beats with in_valid low for 2 cycles between beats 1 and 2 -> two zero cycles appear on every lane between those values at per-lane skew; 3 beats accepted; done 3 cycles after last accept.
REQ-033 Full 4x4 array of PE_FP16-style PEs fed by this block, A=I, B = values 1..16 row-major, k_len=4 -> PE(i,j) accumulated sums equal B[i][j] once outputs settle.
REQ-034 start with k_len=0 -> in_ready stays 0, done pulses one cycle after start edge, edges stay 0.
REQ-035 rst pulse in FEED after 2 of 4 beats -> all outputs 0 asynchronously, no done; new start k_len=2 runs normally.
REQ-036 start pulsed during FEED and FLUSH -> ignored; beat count and done timing unchanged.
